counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter N_BITS, default 8, SHALL set the width of the external counter value and the period register.
REQ-002 Parameter PRESC_BITS, default 4, SHALL set the width of the prescaler divide value.
REQ-003 clk  in  1  main FPGA clock; all state SHALL update on its rising edge only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  single-cycle request to begin timing; sampled only in IDLE.
REQ-006 stop  in  1  abort request; sampled in every state.
REQ-007 periodic  in  1  mode select, latched at start: 1 = auto-reload, 0 = one-shot.
REQ-008 period  in  N_BITS  terminal count, latched at start.
REQ-009 presc  in  PRESC_BITS  prescale value, latched at start; the counter advances once every presc+1 cycles.
REQ-010 count  in  N_BITS  current value of the controlled counter, which is registered and has a synchronous clear.
REQ-011 cnt_rst  out  1  synchronous clear to the controlled counter.
REQ-012 cnt_en  out  1  count enable to the controlled counter.
REQ-013 busy  out  1  high in LOAD and RUN.
REQ-014 tick  out  1  one-cycle pulse on each terminal count.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and RUN.
REQ-016 IDLE: start=1 and stop=0 SHALL latch period_q, presc_q and mode_q, then go to LOAD. All other IDLE input combinations SHALL leave the FSM in IDLE.
REQ-017 LOAD: cnt_rst=1, the prescaler SHALL clear to 0, and the FSM SHALL go to RUN unconditionally, unless stop=1.
REQ-018 RUN prescaler: the prescaler SHALL count 0..presc_q and wrap to 0. The strobe SHALL be high in the cycle where the prescaler equals presc_q.
REQ-019 RUN, strobe=1 and count!=period_q: cnt_en=1 for that cycle only.
REQ-020 RUN, strobe=1 and count==period_q: tick=1, cnt_en=0, cnt_rst=1.
REQ-021 On the REQ-020 event with mode_q=1, the FSM SHALL remain in RUN. The prescaler wrap SHALL restart the next interval with no idle cycle.
REQ-022 On the REQ-020 event with mode_q=0, the FSM SHALL go to IDLE.
REQ-023 The tick period SHALL be exactly (period_q+1)*(presc_q+1) cycles. In one-shot mode, the first tick SHALL occur in the (period_q+1)*(presc_q+1)-th RUN cycle.
REQ-024 cnt_en, cnt_rst and tick SHALL be combinational decodes of registered state, the prescaler and the count input. No additional register stage SHALL be inserted.
REQ-025 cnt_en and cnt_rst SHALL never be high in the same cycle.
REQ-026 stop=1 in LOAD or RUN SHALL force IDLE next cycle, with cnt_rst=1 and tick=0 in the stop cycle. stop SHALL win over a simultaneous terminal count.
REQ-027 start while busy SHALL be ignored: no retrigger, and latched values SHALL be unchanged.
REQ-028 period=0, presc=0 SHALL be legal. In periodic mode this SHALL give tick=1 in every RUN cycle.
REQ-029 Changes on period, presc or periodic after start SHALL have no effect until the next start from IDLE.
REQ-030 All arithmetic SHALL be unsigned. There SHALL be no count wrap beyond period_q. The prescaler compare SHALL be an equality test at PRESC_BITS width.

Reset
REQ-031 While rst=1: state=IDLE, prescaler=0, period_q=0, presc_q=0, mode_q=0.
REQ-032 While rst=1: cnt_rst=1, cnt_en=0, tick=0, busy=0.
REQ-033 rst SHALL override start and stop. Reset asserted mid-RUN SHALL produce IDLE on the next edge with no tick.

Verification
REQ-034 A bench SHALL apply rst for 2 cycles -> busy=0, tick=0, cnt_en=0 and cnt_rst=1 throughout; IDLE on release.
REQ-035 A bench SHALL apply one-shot, period=3, presc=1, start pulse -> LOAD 1 cycle; tick at RUN cycle 8; cnt_en pulses at RUN cycles 2, 4 and 6; IDLE after; busy low after tick.
REQ-036 A bench SHALL apply periodic, period=4, presc=0 -> ticks every 5 cycles for 3 intervals; count sequence 0,1,2,3,4,0...; no gap cycles.
REQ-037 A bench SHALL apply stop in the same cycle as a terminal count (periodic, period=2, presc=2) -> tick=0, cnt_rst=1, IDLE next cycle.
REQ-038 A bench SHALL apply start, then during RUN apply start again with period changed 5 -> 9 -> no retrigger; tick timing still uses period=5.
REQ-039 A bench SHALL apply periodic, period=0, presc=0 -> tick=1 in every RUN cycle and cnt_en=0 always; stop -> IDLE.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if
// Groups the control, configuration and counter-facing signals of
// counter_ctrl into one bundle.
//   start, stop    : timing request / abort from the host
//   periodic       : 1 = auto-reload, 0 = one-shot (latched at start)
//   period, presc  : terminal count and prescale value (latched at start)
//   count          : current value of the external controlled counter
//   cnt_rst, cnt_en: synchronous clear / enable for that counter
//   busy, tick     : status and one-cycle terminal-count pulse
// The slave modport is the controller side; master is the host/counter side.
interface counter_ctrl_if #(
    parameter int N_BITS     = 8,
    parameter int PRESC_BITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  periodic;
    logic [N_BITS-1:0]     period;
    logic [PRESC_BITS-1:0] presc;
    logic [N_BITS-1:0]     count;
    logic                  cnt_rst;
    logic                  cnt_en;
    logic                  busy;
    logic                  tick;

    modport slave (
        input  start, stop, periodic, period, presc, count,
        output cnt_rst, cnt_en, busy, tick
    );

    modport master (
        output start, stop, periodic, period, presc, count,
        input  cnt_rst, cnt_en, busy, tick
    );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl
// Controls an external registered counter (synchronous clear) to produce
// a tick every (period+1)*(presc+1) cycles, one-shot or auto-reload.
// Ports:
//   clk : rising-edge clock for all state
//   rst : synchronous, active-high reset
//   bus : counter_ctrl_if.slave carrying start/stop/periodic/period/presc/
//         count in and cnt_rst/cnt_en/busy/tick out
// All outputs are combinational decodes of registered state, the prescaler
// and the count input, so the counter sees them in the same cycle.
module counter_ctrl #(
    parameter int N_BITS     = 8,
    parameter int PRESC_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PRESC_BITS-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [N_BITS-1:0]     period_q, period_d;
    logic                  mode_q, mode_d;

    logic strobe;
    logic terminal;
    logic cnt_rst_c;
    logic cnt_en_c;
    logic busy_c;
    logic tick_c;

    // strobe marks the last cycle of each prescale interval; the counter
    // only advances or terminates on such cycles.
    assign strobe   = (state_q == RUN) && (presc_cnt_q == presc_q);
    assign terminal = strobe && (bus.count == period_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_cnt_q <= '0;
            presc_q     <= '0;
            period_q    <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_cnt_q <= presc_cnt_d;
            presc_q     <= presc_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        presc_cnt_d = presc_cnt_q;
        presc_d     = presc_q;
        period_d    = period_q;
        mode_d      = mode_q;
        cnt_rst_c   = 1'b0;
        cnt_en_c    = 1'b0;
        busy_c      = 1'b0;
        tick_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Configuration is only captured here, so start or config
                // changes while busy cannot retrigger or alter a run.
                if (bus.start && !bus.stop) begin
                    period_d = bus.period;
                    presc_d  = bus.presc;
                    mode_d   = bus.periodic;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                busy_c      = 1'b1;
                cnt_rst_c   = 1'b1;
                presc_cnt_d = '0;
                state_d     = bus.stop ? IDLE : RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (bus.stop) begin
                    // stop takes priority over a coincident terminal count
                    cnt_rst_c   = 1'b1;
                    presc_cnt_d = '0;
                    state_d     = IDLE;
                end else if (strobe) begin
                    // Wrapping the prescaler here starts the next interval
                    // immediately in auto-reload mode.
                    presc_cnt_d = '0;
                    if (terminal) begin
                        tick_c    = 1'b1;
                        cnt_rst_c = 1'b1;
                        if (!mode_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_en_c = 1'b1;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset forces the counter clear and silences everything else even
        // in the cycle where the state register has not yet returned to IDLE.
        if (rst) begin
            cnt_rst_c = 1'b1;
            cnt_en_c  = 1'b0;
            busy_c    = 1'b0;
            tick_c    = 1'b0;
        end
    end

    assign bus.cnt_rst = cnt_rst_c;
    assign bus.cnt_en  = cnt_en_c;
    assign bus.busy    = busy_c;
    assign bus.tick    = tick_c;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
// Self-checking bench for counter_ctrl. Each vector carries the inputs for
// one clock cycle and the expected {cnt_rst, cnt_en, busy, tick} for that
// cycle. Expectations are queued when a vector is driven and popped when the
// outputs are sampled on the following falling edge. A behavioural model of
// the controlled counter closes the loop through count.
module tb_counter_ctrl;

    localparam int N_BITS     = 8;
    localparam int PRESC_BITS = 4;

    // Expected-output encodings, {cnt_rst, cnt_en, busy, tick}
    localparam logic [3:0] E_IDLE = 4'b0000;
    localparam logic [3:0] E_RST  = 4'b1000;
    localparam logic [3:0] E_LOAD = 4'b1010;
    localparam logic [3:0] E_WAIT = 4'b0010;
    localparam logic [3:0] E_EN   = 4'b0110;
    localparam logic [3:0] E_TICK = 4'b1011;
    localparam logic [3:0] E_STOP = 4'b1010;

    typedef struct {
        logic                  rst;
        logic                  start;
        logic                  stop;
        logic                  periodic;
        logic [N_BITS-1:0]     period;
        logic [PRESC_BITS-1:0] presc;
        logic [3:0]            exp;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        int         id;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    counter_ctrl_if #(.N_BITS(N_BITS), .PRESC_BITS(PRESC_BITS)) bus ();

    counter_ctrl #(.N_BITS(N_BITS), .PRESC_BITS(PRESC_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model of the controlled counter: registered, synchronous clear.
    always_ff @(posedge clk) begin
        if (bus.cnt_rst) begin
            bus.count <= '0;
        end else if (bus.cnt_en) begin
            bus.count <= bus.count + 1'b1;
        end
    end

    vec_t table_q[$];
    sb_t  sb_q[$];
    int   n_applied = 0;
    int   n_miscompares = 0;
    int   vec_id = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic p,
                                input logic per, input logic [N_BITS-1:0] prd,
                                input logic [PRESC_BITS-1:0] ps,
                                input logic [3:0] e);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.periodic = per;
        v.period = prd; v.presc = ps; v.exp = e;
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic applyStimulus(input vec_t v);
        sb_t e;
        @(posedge clk);
        #1;
        rst          = v.rst;
        bus.start    = v.start;
        bus.stop     = v.stop;
        bus.periodic = v.periodic;
        bus.period   = v.period;
        bus.presc    = v.presc;
        e.exp = v.exp;
        e.id  = vec_id;
        vec_id++;
        sb_q.push_back(e);
    endtask

    // Sample on the falling edge and compare with the oldest expectation.
    task automatic checkOutput();
        sb_t        e;
        logic [3:0] got;
        @(negedge clk);
        e   = sb_q.pop_front();
        got = {bus.cnt_rst, bus.cnt_en, bus.busy, bus.tick};
        n_applied++;
        if (got !== e.exp) begin
            n_miscompares++;
            $display("[TB] FAIL vector %0d {cnt_rst,cnt_en,busy,tick} got %b expected %b (count=%0d)",
                     e.id, got, e.exp, bus.count);
        end
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.periodic = 1'b0;
        bus.period = '0; bus.presc = '0;

        // Reset held two cycles, start ignored under reset, IDLE on release
        table_q.push_back(mk(1, 0, 0, 0, 0, 0, E_RST));
        table_q.push_back(mk(1, 1, 0, 0, 0, 0, E_RST));
        table_q.push_back(mk(0, 0, 0, 0, 0, 0, E_IDLE));
        table_q.push_back(mk(0, 0, 0, 0, 0, 0, E_IDLE));

        // One-shot, period=3, presc=1: enables at RUN 2,4,6, tick at RUN 8
        table_q.push_back(mk(0, 1, 0, 0, 3, 1, E_IDLE));
        table_q.push_back(mk(0, 0, 0, 0, 3, 1, E_LOAD));
        for (int c = 1; c <= 8; c++) begin
            if (c == 8)          table_q.push_back(mk(0, 0, 0, 0, 3, 1, E_TICK));
            else if (c % 2 == 0) table_q.push_back(mk(0, 0, 0, 0, 3, 1, E_EN));
            else                 table_q.push_back(mk(0, 0, 0, 0, 3, 1, E_WAIT));
        end
        table_q.push_back(mk(0, 0, 0, 0, 3, 1, E_IDLE));

        // Periodic, period=4, presc=0: tick every 5th cycle, no gaps, 3 intervals
        table_q.push_back(mk(0, 1, 0, 1, 4, 0, E_IDLE));
        table_q.push_back(mk(0, 0, 0, 1, 4, 0, E_LOAD));
        for (int c = 1; c <= 15; c++) begin
            table_q.push_back(mk(0, 0, 0, 1, 4, 0, (c % 5 == 0) ? E_TICK : E_EN));
        end
        table_q.push_back(mk(0, 0, 1, 1, 4, 0, E_STOP));
        table_q.push_back(mk(0, 0, 0, 1, 4, 0, E_IDLE));

        // start with stop in IDLE is not a start; stop during LOAD aborts
        table_q.push_back(mk(0, 1, 1, 0, 2, 0, E_IDLE));
        table_q.push_back(mk(0, 0, 0, 0, 2, 0, E_IDLE));
        table_q.push_back(mk(0, 1, 0, 0, 2, 0, E_IDLE));
        table_q.push_back(mk(0, 0, 1, 0, 2, 0, E_LOAD));
        table_q.push_back(mk(0, 0, 0, 0, 2, 0, E_IDLE));

        foreach (table_q[i]) begin
            step(table_q[i]);
        end

        // Stop coincident with terminal count (periodic, period=2, presc=2)
        step(mk(0, 1, 0, 1, 2, 2, E_IDLE));
        step(mk(0, 0, 0, 1, 2, 2, E_LOAD));
        for (int c = 1; c <= 8; c++) begin
            step(mk(0, 0, 0, 1, 2, 2, (c % 3 == 0) ? E_EN : E_WAIT));
        end
        step(mk(0, 0, 1, 1, 2, 2, E_STOP));
        step(mk(0, 0, 0, 1, 2, 2, E_IDLE));

        // Retrigger attempt: one-shot period=5; at RUN 2 start again with
        // period=9, presc=3, periodic=1. Tick must still come at RUN 6.
        step(mk(0, 1, 0, 0, 5, 0, E_IDLE));
        step(mk(0, 0, 0, 0, 5, 0, E_LOAD));
        step(mk(0, 0, 0, 0, 5, 0, E_EN));
        step(mk(0, 1, 0, 1, 9, 3, E_EN));
        for (int c = 3; c <= 5; c++) begin
            step(mk(0, 0, 0, 1, 9, 3, E_EN));
        end
        step(mk(0, 0, 0, 1, 9, 3, E_TICK));
        step(mk(0, 0, 0, 1, 9, 3, E_IDLE));
        step(mk(0, 0, 0, 1, 9, 3, E_IDLE));

        // period=0, presc=0 periodic: tick every RUN cycle, never enable
        step(mk(0, 1, 0, 1, 0, 0, E_IDLE));
        step(mk(0, 0, 0, 1, 0, 0, E_LOAD));
        for (int c = 1; c <= 6; c++) begin
            step(mk(0, 0, 0, 1, 0, 0, E_TICK));
        end
        step(mk(0, 0, 1, 1, 0, 0, E_STOP));
        step(mk(0, 0, 0, 1, 0, 0, E_IDLE));

        // Reset mid-RUN, with start held: no tick, IDLE after release
        step(mk(0, 1, 0, 1, 3, 0, E_IDLE));
        step(mk(0, 0, 0, 1, 3, 0, E_LOAD));
        step(mk(0, 0, 0, 1, 3, 0, E_EN));
        step(mk(0, 0, 0, 1, 3, 0, E_EN));
        step(mk(0, 0, 0, 1, 3, 0, E_EN));
        step(mk(1, 1, 0, 1, 3, 0, E_RST));
        step(mk(0, 0, 0, 1, 3, 0, E_IDLE));
        step(mk(0, 0, 0, 1, 3, 0, E_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
